// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS32 core write-back path.
//   wb_src_e   - write-back source select (ALU result, aligned load data, link address)
//   ld_type_e  - load width/sign encodings; unlisted codes behave as lw
//   REG_ZERO   - the hardwired $zero register address
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_LOAD = 2'b01,
    WB_SRC_LINK = 2'b10,
    WB_SRC_RSVD = 2'b11
  } wb_src_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LBU = 3'b001,
    LD_LH  = 3'b010,
    LD_LHU = 3'b011,
    LD_LW  = 3'b100
  } ld_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load extraction for the write-back stage.
// Picks the addressed little-endian byte or half-word lane out of the raw
// memory word, sign- or zero-extends it, and flags misaligned accesses.
// Ports:
//   loadType_i    load encoding (lb/lbu/lh/lhu/lw, anything else as lw)
//   offset_i      low two bits of the effective address
//   word_i        raw aligned word from data memory
//   data_o        extended load result
//   misaligned_o  half with odd offset, or word with non-zero offset
module load_align #(
  parameter int DW = 32
) (
  input  logic [2:0]    loadType_i,
  input  logic [1:0]    offset_i,
  input  logic [DW-1:0] word_i,
  output logic [DW-1:0] data_o,
  output logic          misaligned_o
);
  import mips_pkg::*;

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = word_i[7:0];
    case (offset_i)
      2'd0:    byteLane = word_i[7:0];
      2'd1:    byteLane = word_i[15:8];
      2'd2:    byteLane = word_i[23:16];
      default: byteLane = word_i[31:24];
    endcase
    // Half-word lane is chosen by offset bit 1 only; bit 0 just flags misalignment.
    halfLane = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (loadType_i)
      LD_LB:  data_o = {{(DW-8){byteLane[7]}}, byteLane};
      LD_LBU: data_o = {{(DW-8){1'b0}}, byteLane};
      LD_LH: begin
        data_o       = {{(DW-16){halfLane[15]}}, halfLane};
        misaligned_o = offset_i[0];
      end
      LD_LHU: begin
        data_o       = {{(DW-16){1'b0}}, halfLane};
        misaligned_o = offset_i[0];
      end
      default: begin
        data_o       = word_i;
        misaligned_o = (offset_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back stage; drives the
// register-file write port one cycle after the MEM stage.
// Optional feature: define WB_PERF_EN to build the retired-instruction counter;
// otherwise InstRetired is tied to zero.
// Ports:
//   clk, Reset           clock, asynchronous active-low reset
//   Stall, Flush         hazard-unit controls (Flush wins)
//   Mem*                 MEM-stage instruction fields being captured
//   RegWrite/WriteAddr/WriteData   regfile write port
//   WbValid              WB holds a valid instruction
//   AddrErr              misaligned load sitting in WB
//   InstRetired          retired count (WB_PERF_EN only)
module mem_wb_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             MemValid,
  input  logic             MemRegWrite,
  input  logic [AW-1:0]    MemDest,
  input  logic [1:0]       MemWbSrc,
  input  logic [2:0]       MemLoadType,
  input  logic [DW-1:0]    MemAluRes,
  input  logic [DW-1:0]    MemLoadWord,
  input  logic [DW-1:0]    MemPcPlus8,
  output logic             RegWrite,
  output logic [AW-1:0]    WriteAddr,
  output logic [DW-1:0]    WriteData,
  output logic             WbValid,
  output logic             AddrErr,
  output logic [CNT_W-1:0] InstRetired
);
  import mips_pkg::*;

  logic          wbValid_q, wbValid_d;
  logic          regWr_q;
  logic [AW-1:0] dest_q;
  logic [1:0]    wbSrc_q;
  logic [2:0]    loadType_q;
  logic [DW-1:0] aluRes_q;
  logic [DW-1:0] loadWord_q;
  logic [DW-1:0] pcPlus8_q;

  logic          advance;
  logic [DW-1:0] loadData;
  logic          misaligned;

  // The stage moves on unless stalled; a flush always moves it on (as a bubble).
  assign advance = !Stall || Flush;

  always_comb begin
    wbValid_d = wbValid_q;
    if (Flush)       wbValid_d = 1'b0;
    else if (!Stall) wbValid_d = MemValid;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wbValid_q  <= 1'b0;
      regWr_q    <= 1'b0;
      dest_q     <= '0;
      wbSrc_q    <= '0;
      loadType_q <= '0;
      aluRes_q   <= '0;
      loadWord_q <= '0;
      pcPlus8_q  <= '0;
    end else begin
      wbValid_q <= wbValid_d;
      // Payload is left untouched on flush; WbValid alone masks it.
      if (!Stall && !Flush) begin
        regWr_q    <= MemRegWrite;
        dest_q     <= MemDest;
        wbSrc_q    <= MemWbSrc;
        loadType_q <= MemLoadType;
        aluRes_q   <= MemAluRes;
        loadWord_q <= MemLoadWord;
        pcPlus8_q  <= MemPcPlus8;
      end
    end
  end

  load_align #(.DW(DW)) u_load_align (
    .loadType_i   (loadType_q),
    .offset_i     (aluRes_q[1:0]),
    .word_i       (loadWord_q),
    .data_o       (loadData),
    .misaligned_o (misaligned)
  );

  assign AddrErr = wbValid_q && (wbSrc_q == WB_SRC_LOAD) && misaligned;

  // Reserved source code falls through to the ALU result.
  always_comb begin
    WriteData = aluRes_q;
    case (wbSrc_q)
      WB_SRC_LOAD: WriteData = loadData;
      WB_SRC_LINK: WriteData = pcPlus8_q;
      default:     WriteData = aluRes_q;
    endcase
  end

  assign RegWrite  = wbValid_q && regWr_q && (dest_q != REG_ZERO) && !AddrErr;
  assign WriteAddr = wbValid_q ? dest_q : '0;
  assign WbValid   = wbValid_q;

`ifdef WB_PERF_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (wbValid_q && advance) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign InstRetired = retired_q;
`else
  logic unusedAdvance;
  assign unusedAdvance = advance;
  assign InstRetired   = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. A driver applies
// directed and random MEM-stage instructions and pushes the predicted write
// for each captured one; a monitor pops and compares whenever WB presents a
// newly captured instruction, and re-checks the held one during stalls.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Stall = 1'b0;
  logic             Flush = 1'b0;
  logic             MemValid = 1'b0;
  logic             MemRegWrite = 1'b0;
  logic [AW-1:0]    MemDest = '0;
  logic [1:0]       MemWbSrc = '0;
  logic [2:0]       MemLoadType = '0;
  logic [DW-1:0]    MemAluRes = '0;
  logic [DW-1:0]    MemLoadWord = '0;
  logic [DW-1:0]    MemPcPlus8 = '0;
  logic             RegWrite;
  logic [AW-1:0]    WriteAddr;
  logic [DW-1:0]    WriteData;
  logic             WbValid;
  logic             AddrErr;
  logic [CNT_W-1:0] InstRetired;

  mem_wb_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Flush       (Flush),
    .MemValid    (MemValid),
    .MemRegWrite (MemRegWrite),
    .MemDest     (MemDest),
    .MemWbSrc    (MemWbSrc),
    .MemLoadType (MemLoadType),
    .MemAluRes   (MemAluRes),
    .MemLoadWord (MemLoadWord),
    .MemPcPlus8  (MemPcPlus8),
    .RegWrite    (RegWrite),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WbValid     (WbValid),
    .AddrErr     (AddrErr),
    .InstRetired (InstRetired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regWr;
    logic [4:0]  dest;
    logic [1:0]  src;
    logic [2:0]  ltype;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] pc8;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t             expQ[$];
  exp_t             cur;
  int               checks = 0;
  int               passes = 0;
  bit               monEn = 1'b0;
  logic             modelValid = 1'b0;
  logic [CNT_W-1:0] modelCnt = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Reference model: the write an instruction should produce, computed from
  // byte-lane arithmetic on the memory word.
  function automatic exp_t predict(input stim_t s);
    exp_t        e;
    int          off;
    logic [31:0] b, h, ld;
    bit          mis;
    bit          isLoad;
    off = int'(s.alu % 4);
    b   = (s.word >> (8 * off)) & 32'hFF;
    h   = (s.word >> (16 * (off / 2))) & 32'hFFFF;
    mis = 1'b0;
    case (s.ltype)
      3'd0: ld = (b >= 32'd128) ? b - 32'd256 : b;
      3'd1: ld = b;
      3'd2: begin ld = (h >= 32'd32768) ? h - 32'd65536 : h; mis = (off % 2) != 0; end
      3'd3: begin ld = h; mis = (off % 2) != 0; end
      default: begin ld = s.word; mis = (off != 0); end
    endcase
    isLoad = (s.src == 2'd1);
    e.err  = isLoad && mis;
    e.data = isLoad ? ld : (s.src == 2'd2) ? s.pc8 : s.alu;
    e.we   = s.regWr && (s.dest != 5'd0) && !e.err;
    e.addr = s.dest;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    MemValid    = s.valid;
    MemRegWrite = s.regWr;
    MemDest     = s.dest;
    MemWbSrc    = s.src;
    MemLoadType = s.ltype;
    MemAluRes   = s.alu;
    MemLoadWord = s.word;
    MemPcPlus8  = s.pc8;
    Stall       = s.stall;
    Flush       = s.flush;
    if (s.valid && !s.stall && !s.flush) expQ.push_back(predict(s));
  endtask

  function automatic stim_t mk(input logic [1:0] src, input logic [2:0] lt, input logic [4:0] dest,
                               input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc8,
                               input logic stall, input logic flush);
    stim_t s;
    s.valid = 1'b1; s.regWr = 1'b1; s.dest = dest; s.src = src; s.ltype = lt;
    s.alu = alu; s.word = word; s.pc8 = pc8; s.stall = stall; s.flush = flush;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.valid = ($urandom_range(0, 9) < 8);
    s.regWr = ($urandom_range(0, 9) < 8);
    s.dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    s.src   = 2'($urandom_range(0, 3));
    s.ltype = 3'($urandom_range(0, 7));
    s.alu   = $urandom;
    s.word  = $urandom;
    s.pc8   = $urandom;
    s.stall = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 8);
    return s;
  endfunction

  // Monitor: tracks the expected valid/retire state and compares outputs
  // shortly after every rising edge.
  initial begin
    bit adv;
    forever begin
      @(posedge clk);
      if (monEn) begin
        adv = !Stall || Flush;
        if (modelValid && adv) modelCnt = modelCnt + 1'b1;
        if (Flush)       modelValid = 1'b0;
        else if (!Stall) modelValid = MemValid;
        #1;
        checkOutput("WbValid", 32'(WbValid), 32'(modelValid));
        if (modelValid) begin
          if (adv) begin
            if (expQ.size() == 0) begin
              checks++;
              $display("[TB] FAIL scoreboard: actual=empty queue required=pending entry");
            end else begin
              cur = expQ.pop_front();
            end
          end
          checkOutput("RegWrite", 32'(RegWrite), 32'(cur.we));
          checkOutput("WriteAddr", 32'(WriteAddr), 32'(cur.addr));
          checkOutput("WriteData", WriteData, cur.data);
          checkOutput("AddrErr", 32'(AddrErr), 32'(cur.err));
        end else begin
          checkOutput("RegWrite_idle", 32'(RegWrite), 32'd0);
          checkOutput("WriteAddr_idle", 32'(WriteAddr), 32'd0);
          checkOutput("AddrErr_idle", 32'(AddrErr), 32'd0);
        end
`ifdef WB_PERF_EN
        checkOutput("InstRetired", InstRetired, modelCnt);
`else
        checkOutput("InstRetired", InstRetired, 32'd0);
`endif
      end
    end
  end

  initial begin
    stim_t dir[$];
    stim_t s;
    localparam logic [31:0] LW_PAT = 32'h8081_7F02;

    #1 Reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("reset_WriteAddr", 32'(WriteAddr), 32'd0);
    checkOutput("reset_WriteData", WriteData, 32'd0);
    checkOutput("reset_WbValid", 32'(WbValid), 32'd0);
    checkOutput("reset_AddrErr", 32'(AddrErr), 32'd0);
    checkOutput("reset_InstRetired", InstRetired, 32'd0);
    Reset = 1'b1;
    monEn = 1'b1;

    dir.push_back(mk(2'd0, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd0, 3'd0, 5'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd0, 5'd8, 32'h0000_1003, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd1, 5'd9, 32'h0000_1003, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd2, 5'd10, 32'h0000_2002, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd3, 5'd11, 32'h0000_2000, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd4, 5'd12, 32'h0000_3002, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd2, 5'd13, 32'h0000_3001, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd1, 3'd0, 5'd14, 32'h0000_3001, LW_PAT, 32'h0, 1'b0, 1'b0));
    dir.push_back(mk(2'd2, 3'd0, 5'd31, 32'hDEAD_BEEF, 32'h0, 32'h0040_0010, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      dir.push_back(mk(2'd0, 3'd0, 5'd3, 32'hBAD0_0000, 32'h0, 32'h0, 1'b1, 1'b0));
    dir.push_back(mk(2'd0, 3'd0, 5'd4, 32'hBAD0_0001, 32'h0, 32'h0, 1'b1, 1'b1));
    dir.push_back(mk(2'd0, 3'd0, 5'd6, 32'h0000_5678, 32'h0, 32'h0, 1'b0, 1'b0));
    foreach (dir[i]) applyStimulus(dir[i]);

    for (int i = 0; i < 400; i++) applyStimulus(rnd());

    s = rnd();
    s.valid = 1'b0; s.stall = 1'b0; s.flush = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    // Asynchronous reset while WB holds a valid write.
    monEn = 1'b0;
    s = mk(2'd0, 3'd0, 5'd7, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(s);
    void'(expQ.pop_back());
    @(posedge clk);
    #1;
    checkOutput("pre_reset_WbValid", 32'(WbValid), 32'd1);
    checkOutput("pre_reset_WriteData", WriteData, 32'hCAFE_F00D);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("async_WriteAddr", 32'(WriteAddr), 32'd0);
    checkOutput("async_WriteData", WriteData, 32'd0);
    checkOutput("async_WbValid", 32'(WbValid), 32'd0);
    checkOutput("async_AddrErr", 32'(AddrErr), 32'd0);
    checkOutput("async_InstRetired", InstRetired, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
